// File: rtl/vcr_ugal_source_mc_if.sv
// Flit-side bundle of the UGAL source decision unit: incoming flit
// descriptor plus the resulting route class and intermediate router.
interface vcr_ugal_source_mc_if #(
    parameter int num_vcs           = 2,
    parameter int router_addr_width = 4,
    parameter int node_addr_width   = 2
);
    logic                                         flit_valid;
    logic                                         flit_head;
    logic [num_vcs-1:0]                           flit_vc;
    logic [router_addr_width+node_addr_width-1:0] dest_info;
    logic [router_addr_width-1:0]                 intm_router_address;
    logic                                         route_min;

    modport master (
        output flit_valid, flit_head, flit_vc, dest_info,
        input  intm_router_address, route_min
    );

    modport slave (
        input  flit_valid, flit_head, flit_vc, dest_info,
        output intm_router_address, route_min
    );
endinterface

// File: rtl/vcr_ugal_source_mc.sv
// UGAL source-routing decision for a flattened-butterfly injection port:
// random intermediate sampling, weighted min/non-min compare, per-VC latch.
module vcr_ugal_source_mc #(
    parameter int num_flit_buffers     = 8,
    parameter int num_vcs              = 2,
    parameter int num_routers_per_dim  = 4,
    parameter int num_dimensions       = 2,
    parameter int num_nodes_per_router = 4,
    parameter int num_candidates       = 2,
    parameter int ugal_threshold       = 3,
    parameter int min_weight           = 1,
    parameter int nonmin_weight        = 2,
    localparam int DW   = $clog2(num_routers_per_dim),
    localparam int RAW  = num_dimensions * DW,
    localparam int NODW = $clog2(num_nodes_per_router),
    localparam int NP   = num_dimensions * (num_routers_per_dim - 1),
    localparam int CCW  = $clog2(num_vcs * num_flit_buffers) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    vcr_ugal_source_mc_if.slave   flit_if,
    input  logic [1:0]            mode_i,
    input  logic [RAW-1:0]        src_router_address_i,
    input  logic [NP*CCW-1:0]     credit_count_i,
    output logic [15:0]           nonmin_decisions_o
);
    localparam int PW   = (NP > 1) ? $clog2(NP) : 1;
    localparam int VW   = (num_vcs > 1) ? $clog2(num_vcs) : 1;
    localparam int LW   = num_candidates * RAW;
    localparam int CMPW = CCW + 4;

    // Fibonacci feedback masks for maximal-length sequences (bit n-1 = tap n).
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            2:  return 32'h0000_0003;
            3:  return 32'h0000_0006;
            4:  return 32'h0000_000C;
            5:  return 32'h0000_0014;
            6:  return 32'h0000_0030;
            7:  return 32'h0000_0060;
            8:  return 32'h0000_00B8;
            9:  return 32'h0000_0110;
            10: return 32'h0000_0240;
            11: return 32'h0000_0500;
            12: return 32'h0000_0829;
            13: return 32'h0000_100D;
            14: return 32'h0000_2015;
            15: return 32'h0000_6000;
            16: return 32'h0000_D008;
            20: return 32'h0009_0000;
            24: return 32'h00E1_0000;
            28: return 32'h0900_0000;
            32: return 32'h8020_0003;
            default: return (32'h1 << (w - 1)) | 32'h1;
        endcase
    endfunction

    localparam logic [LW-1:0] TAPS = LW'(lfsr_taps(LW));

    function automatic logic [DW-1:0] digit(input logic [RAW-1:0] a, input int d);
        return a[(num_dimensions-1-d)*DW +: DW];
    endfunction

    function automatic logic [PW-1:0] first_hop(input logic [RAW-1:0] a, input logic [RAW-1:0] s);
        logic [PW-1:0] p;
        logic          found;
        p     = '0;
        found = 1'b0;
        for (int d = 0; d < num_dimensions; d++) begin
            if (!found && digit(a, d) != digit(s, d)) begin
                found = 1'b1;
                if (digit(a, d) < digit(s, d))
                    p = PW'(d * (num_routers_per_dim - 1)) + PW'(digit(a, d));
                else
                    p = PW'(d * (num_routers_per_dim - 1)) + PW'(digit(a, d)) - PW'(1);
            end
        end
        return p;
    endfunction

    function automatic logic [CCW-1:0] occ_of(input logic [NP*CCW-1:0] cc, input logic [PW-1:0] p);
        return cc[(NP-1-int'(p))*CCW +: CCW];
    endfunction

    // Digit-wise modular add; no carry crosses a dimension boundary.
    function automatic logic [RAW-1:0] add_dig(input logic [RAW-1:0] a, input logic [RAW-1:0] b);
        logic [RAW-1:0] r;
        r = '0;
        for (int d = 0; d < num_dimensions; d++)
            r[(num_dimensions-1-d)*DW +: DW] = digit(a, d) + digit(b, d);
        return r;
    endfunction

    logic [LW-1:0]  lfsr_q, lfsr_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           vc_min_q  [num_vcs];
    logic [RAW-1:0] vc_intm_q [num_vcs];

    logic [RAW-1:0]  dest_rtr;
    logic [NODW-1:0] unused_dest_node;
    logic            head_fire, vc_onehot;
    logic [PW-1:0]   pmin, hop;
    logic [CCW-1:0]  occ_min, occ_c, best_occ;
    logic [RAW-1:0]  cand, best_intm;
    logic [CMPW-1:0] lhs, rhs;
    logic            cmp_min, head_min;
    logic [RAW-1:0]  head_intm;
    logic [VW-1:0]   rd_idx;
    logic            rd_found;

    assign dest_rtr         = flit_if.dest_info[NODW +: RAW];
    assign unused_dest_node = flit_if.dest_info[NODW-1:0];
    assign head_fire        = flit_if.flit_valid & flit_if.flit_head;
    assign vc_onehot        = (flit_if.flit_vc != '0) &&
                              ((flit_if.flit_vc & (flit_if.flit_vc - num_vcs'(1))) == '0);

    always_comb begin
        pmin      = first_hop(dest_rtr, src_router_address_i);
        occ_min   = occ_of(credit_count_i, pmin);
        best_occ  = '0;
        best_intm = src_router_address_i;
        hop       = '0;
        occ_c     = '0;
        cand      = '0;
        for (int i = 0; i < num_candidates; i++) begin
            cand  = add_dig(src_router_address_i, lfsr_q[i*RAW +: RAW]);
            hop   = (cand == src_router_address_i) ? pmin : first_hop(cand, src_router_address_i);
            occ_c = occ_of(credit_count_i, hop);
            if (i == 0 || occ_c < best_occ) begin
                best_occ  = occ_c;
                best_intm = cand;
            end
        end

        lhs     = CMPW'(occ_min) * CMPW'(min_weight);
        rhs     = CMPW'(best_occ) * CMPW'(nonmin_weight) + CMPW'(ugal_threshold);
        cmp_min = (lhs <= rhs);

        if (dest_rtr == src_router_address_i) head_min = 1'b1;
        else if (mode_i == 2'b01)             head_min = 1'b1;
        else if (mode_i == 2'b10)             head_min = 1'b0;
        else                                  head_min = cmp_min;
        head_intm = head_min ? src_router_address_i : best_intm;

        rd_idx   = '0;
        rd_found = 1'b0;
        for (int v = 0; v < num_vcs; v++) begin
            if (!rd_found && flit_if.flit_vc[v]) begin
                rd_idx   = VW'(v);
                rd_found = 1'b1;
            end
        end

        if (head_fire) begin
            flit_if.route_min           = head_min;
            flit_if.intm_router_address = head_intm;
        end else begin
            flit_if.route_min           = vc_min_q[rd_idx];
            flit_if.intm_router_address = vc_intm_q[rd_idx];
        end

        lfsr_d = head_fire ? {lfsr_q[LW-2:0], ^(lfsr_q & TAPS)} : lfsr_q;
        cnt_d  = cnt_q;
        if (head_fire && !head_min && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LW'(1);
            cnt_q  <= '0;
            for (int v = 0; v < num_vcs; v++) begin
                vc_min_q[v]  <= 1'b1;
                vc_intm_q[v] <= '0;
            end
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
            for (int v = 0; v < num_vcs; v++) begin
                if (head_fire && vc_onehot && flit_if.flit_vc[v]) begin
                    vc_min_q[v]  <= head_min;
                    vc_intm_q[v] <= head_intm;
                end
            end
        end
    end

    assign nonmin_decisions_o = cnt_q;
endmodule

// File: tb/tb_vcr_ugal_source_mc.sv
// Scoreboard bench for vcr_ugal_source_mc at default parameters.
module tb_vcr_ugal_source_mc;
    localparam int R = 4, ND = 2, DW = 2, RAW = 4, NODW = 2, NP = 6, CCW = 5;
    localparam int THR = 3, MW = 1, NW = 2;

    typedef struct {
        logic       rmin;
        logic [3:0] intm;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  src = 4'h0;
    logic [29:0] cc = '0;
    logic [15:0] nonmin;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];

    logic [7:0]  m_lfsr;
    logic [15:0] m_cnt;
    logic        m_vc_min [2];
    logic [3:0]  m_vc_intm [2];

    vcr_ugal_source_mc_if #(.num_vcs(2), .router_addr_width(4), .node_addr_width(2)) fif ();

    vcr_ugal_source_mc dut (
        .clk                  (clk),
        .reset                (reset),
        .flit_if              (fif),
        .mode_i               (mode),
        .src_router_address_i (src),
        .credit_count_i       (cc),
        .nonmin_decisions_o   (nonmin)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    function automatic int dig(input int a, input int d);
        return (a >> ((ND - 1 - d) * DW)) % R;
    endfunction

    function automatic int hop_of(input int a, input int s);
        for (int d = 0; d < ND; d++) begin
            if (dig(a, d) != dig(s, d))
                return d * (R - 1) + ((dig(a, d) < dig(s, d)) ? dig(a, d) : dig(a, d) - 1);
        end
        return -1;
    endfunction

    function automatic int occ_at(input logic [29:0] c, input int p);
        logic [29:0] t;
        if (p < 0) return 0;
        t = c >> ((NP - 1 - p) * CCW);
        return int'(t[4:0]);
    endfunction

    function automatic int cand_of(input int s, input int slice);
        int r;
        r = 0;
        for (int d = 0; d < ND; d++)
            r = r * R + ((dig(s, d) + dig(slice, d)) % R);
        return r;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [29:0] set_port(input logic [29:0] c, input int p, input int val);
        logic [29:0] m;
        m = 30'h1f << ((NP - 1 - p) * CCW);
        return (c & ~m) | ((30'(val) << ((NP - 1 - p) * CCW)) & m);
    endfunction

    task automatic head_model(input int dest_r, input int s, input logic [1:0] md,
                              input logic [29:0] c, input logic [7:0] lf,
                              output logic rmin, output logic [3:0] intm);
        int pmin, omin, best, bocc, ci, hi, oi;
        logic [7:0] lfv;
        pmin = hop_of(dest_r, s);
        omin = occ_at(c, pmin);
        best = s;
        bocc = 0;
        lfv = lf;
        for (int i = 0; i < 2; i++) begin
            ci = cand_of(s, (i == 0) ? int'(lfv[3:0]) : int'(lfv[7:4]));
            hi = (ci == s) ? pmin : hop_of(ci, s);
            oi = occ_at(c, hi);
            if (i == 0 || oi < bocc) begin
                bocc = oi;
                best = ci;
            end
        end
        if (dest_r == s)      rmin = 1'b1;
        else if (md == 2'b01) rmin = 1'b1;
        else if (md == 2'b10) rmin = 1'b0;
        else                  rmin = (omin * MW <= bocc * NW + THR);
        intm = rmin ? 4'(s) : 4'(best);
    endtask

    task automatic model_reset();
        m_lfsr = 8'h01;
        m_cnt  = 16'h0;
        for (int v = 0; v < 2; v++) begin
            m_vc_min[v]  = 1'b1;
            m_vc_intm[v] = 4'h0;
        end
    endtask

    task automatic do_reset(input int n);
        fif.flit_valid = 1'b0;
        fif.flit_head  = 1'b0;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Called just after a rising edge; holds the flit for one cycle.
    task automatic drive_flit(input logic v, input logic h, input logic [1:0] vc,
                              input logic [3:0] dest_r, input logic [1:0] md,
                              input string tag, output logic [3:0] seen_intm);
        exp_t e;
        logic m;
        logic [3:0] im;
        int rd;
        fif.flit_valid = v;
        fif.flit_head  = h;
        fif.flit_vc    = vc;
        fif.dest_info  = {dest_r, 2'b01};
        mode = md;
        if (v && h) begin
            head_model(int'(dest_r), int'(src), md, cc, m_lfsr, m, im);
        end else begin
            rd = vc[0] ? 0 : (vc[1] ? 1 : 0);
            m  = m_vc_min[rd];
            im = m_vc_intm[rd];
        end
        e.rmin = m;
        e.intm = im;
        e.cnt  = m_cnt;
        sb.push_back(e);

        @(negedge clk);
        e = sb.pop_front();
        seen_intm = fif.intm_router_address;
        checks++;
        if (fif.route_min !== e.rmin) begin
            errors++;
            $display("FAIL %s route_min: got %b, required %b", tag, fif.route_min, e.rmin);
        end
        checks++;
        if (fif.intm_router_address !== e.intm) begin
            errors++;
            $display("FAIL %s intm: got %h, required %h", tag, fif.intm_router_address, e.intm);
        end
        checks++;
        if (nonmin !== e.cnt) begin
            errors++;
            $display("FAIL %s nonmin_decisions: got %h, required %h", tag, nonmin, e.cnt);
        end

        @(posedge clk);
        if (v && h) begin
            if (vc == 2'b01 || vc == 2'b10) begin
                rd = vc[0] ? 0 : 1;
                m_vc_min[rd]  = m;
                m_vc_intm[rd] = im;
            end
            if (!m && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_lfsr = lfsr_step(m_lfsr);
        end
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] s;
        do_reset(2);
        src = 4'h0;
        cc = '0;
        drive_flit(1'b0, 1'b0, 2'b01, 4'h5, 2'b00, "reset_vc0", s);
        drive_flit(1'b0, 1'b0, 2'b10, 4'h5, 2'b00, "reset_vc1", s);
    endtask

    task automatic test_ugal_nonmin();
        logic [3:0] s;
        src = 4'h0;
        cc = set_port(30'h0, 0, 12);
        drive_flit(1'b1, 1'b1, 2'b01, 4'h5, 2'b00, "ugal_nonmin_head", s);
        checks++;
        if (s !== 4'h1) begin
            errors++;
            $display("FAIL ugal_nonmin_cand0: got %h, required %h", s, 4'h1);
        end
        drive_flit(1'b0, 1'b0, 2'b00, 4'h5, 2'b00, "ugal_nonmin_idle", s);
    endtask

    task automatic test_ugal_min();
        logic [3:0] s;
        do_reset(1);
        src = 4'h0;
        cc = set_port(30'h0, 0, 3);
        drive_flit(1'b1, 1'b1, 2'b01, 4'h5, 2'b00, "ugal_min_head", s);
        drive_flit(1'b1, 1'b0, 2'b01, 4'h5, 2'b00, "ugal_min_body", s);
        drive_flit(1'b1, 1'b1, 2'b10, 4'h5, 2'b11, "mode11_head", s);
    endtask

    task automatic test_local_dest();
        logic [3:0] s;
        src = 4'h6;
        cc = '1;
        drive_flit(1'b1, 1'b1, 2'b01, 4'h6, 2'b10, "local_dest_head", s);
        checks++;
        if (s !== 4'h6) begin
            errors++;
            $display("FAIL local_dest_intm: got %h, required %h", s, 4'h6);
        end
        drive_flit(1'b1, 1'b0, 2'b01, 4'h6, 2'b10, "local_dest_body", s);
    endtask

    task automatic test_vc_interleave();
        logic [3:0] s, first;
        src = 4'h0;
        cc = '0;
        drive_flit(1'b1, 1'b1, 2'b01, 4'h5, 2'b10, "vc0_head", first);
        drive_flit(1'b1, 1'b1, 2'b10, 4'hA, 2'b01, "vc1_head", s);
        drive_flit(1'b1, 1'b0, 2'b01, 4'h5, 2'b00, "vc0_body", s);
        checks++;
        if (s !== first) begin
            errors++;
            $display("FAIL vc0_body_keeps_intm: got %h, required %h", s, first);
        end
        drive_flit(1'b1, 1'b0, 2'b10, 4'hA, 2'b00, "vc1_body", s);
        drive_flit(1'b1, 1'b1, 2'b11, 4'h9, 2'b10, "nononehot_head", s);
        drive_flit(1'b1, 1'b0, 2'b11, 4'h9, 2'b00, "nononehot_body", s);
    endtask

    // Advance the LFSR until both candidates have distinct, non-local first hops.
    task automatic find_distinct(output int c0, output int c1, output int h0, output int h1,
                                 output logic ok);
        logic [3:0] s;
        ok = 1'b0;
        c0 = 0; c1 = 0; h0 = 0; h1 = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            c0 = cand_of(int'(src), int'(m_lfsr[3:0]));
            c1 = cand_of(int'(src), int'(m_lfsr[7:4]));
            h0 = (c0 == int'(src)) ? hop_of(5, int'(src)) : hop_of(c0, int'(src));
            h1 = (c1 == int'(src)) ? hop_of(5, int'(src)) : hop_of(c1, int'(src));
            if (h0 != h1 && c0 != c1) ok = 1'b1;
            else drive_flit(1'b1, 1'b1, 2'b10, 4'h5, 2'b01, "cand_advance", s);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cand_search: got no distinct hops, required distinct hops");
        end
    endtask

    task automatic test_candidates();
        int c0, c1, h0, h1;
        logic ok;
        logic [3:0] s;
        src = 4'h0;
        find_distinct(c0, c1, h0, h1, ok);
        if (ok) begin
            cc = set_port(set_port(30'h0, h0, 7), h1, 7);
            drive_flit(1'b1, 1'b1, 2'b01, 4'h5, 2'b10, "cand_tie", s);
            checks++;
            if (s !== 4'(c0)) begin
                errors++;
                $display("FAIL cand_tie_pick: got %h, required %h", s, 4'(c0));
            end
        end
        find_distinct(c0, c1, h0, h1, ok);
        if (ok) begin
            cc = set_port(set_port(30'h0, h0, 7), h1, 2);
            drive_flit(1'b1, 1'b1, 2'b01, 4'h5, 2'b10, "cand_lower", s);
            checks++;
            if (s !== 4'(c1)) begin
                errors++;
                $display("FAIL cand_lower_pick: got %h, required %h", s, 4'(c1));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] s;
        logic [1:0] vc;
        for (int i = 0; i < 60; i++) begin
            src = 4'($urandom_range(0, 15));
            cc  = 30'($urandom);
            vc  = ($urandom_range(0, 7) == 0) ? 2'b11 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
            drive_flit(1'b1, 1'($urandom_range(0, 1)), vc, 4'($urandom_range(0, 15)),
                       2'($urandom_range(0, 3)), "random", s);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] s;
        do_reset(1);
        src = 4'h0;
        cc = '0;
        for (int i = 0; i < 65540; i++)
            drive_flit(1'b1, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 4'h5, 2'b10, "sat", s);
        drive_flit(1'b0, 1'b0, 2'b01, 4'h5, 2'b00, "sat_final", s);
        checks++;
        if (nonmin !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_count: got %h, required %h", nonmin, 16'hFFFF);
        end
        do_reset(1);
        drive_flit(1'b0, 1'b0, 2'b01, 4'h5, 2'b00, "post_reset_vc0", s);
        drive_flit(1'b1, 1'b0, 2'b10, 4'h5, 2'b00, "post_reset_vc1", s);
        checks++;
        if (nonmin !== 16'h0) begin
            errors++;
            $display("FAIL post_reset_count: got %h, required %h", nonmin, 16'h0);
        end
    endtask

    initial begin
        fif.flit_valid = 1'b0;
        fif.flit_head  = 1'b0;
        fif.flit_vc    = 2'b01;
        fif.dest_info  = '0;
        model_reset();
        test_reset();
        test_ugal_nonmin();
        test_ugal_min();
        test_local_dest();
        test_vc_interleave();
        test_candidates();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
